// File: rtl/tx_data_register.sv
// tx_data_register: single-entry USRT transmit holding register; i_Enable writes when empty, i_Done releases, optional sticky o_Overrun via TXDATREG_OVERRUN_EN
module tx_data_register #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_Pclk,
  input  logic                  i_Reset,
  input  logic                  i_Enable,
  input  logic                  i_Done,
  input  logic [DATA_WIDTH-1:0] i_Data,
  output logic [DATA_WIDTH-1:0] o_Data,
  output logic                  o_Busy,
  output logic                  o_Ready
`ifdef TXDATREG_OVERRUN_EN
  ,
  output logic                  o_Overrun
`endif
);
  logic accept;
  assign accept = i_Enable && !o_Busy;
  always_ff @(posedge i_Pclk or negedge i_Reset)
    if (!i_Reset) begin
      o_Data  <= '0;
      o_Busy  <= 1'b0;
      o_Ready <= 1'b0;
    end else begin
      o_Ready <= accept;
      o_Data  <= accept ? i_Data : (o_Busy && i_Done) ? '0 : o_Data;
      o_Busy  <= accept ? 1'b1 : (o_Busy && !i_Done);
    end
`ifdef TXDATREG_OVERRUN_EN
  always_ff @(posedge i_Pclk or negedge i_Reset)
    if (!i_Reset) o_Overrun <= 1'b0;
    else if (i_Enable && o_Busy) o_Overrun <= 1'b1;
`endif
endmodule

// File: tb/tb_tx_data_register.sv
// tb_tx_data_register: table-driven scoreboard bench for tx_data_register
module tb_tx_data_register;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic       done = 1'b0;
  logic [7:0] din = '0;
  logic [7:0] dout;
  logic       busy;
  logic       ready;
`ifdef TXDATREG_OVERRUN_EN
  logic       ov;
`endif
  int errors = 0;
  int checks = 0;
  typedef struct packed {
    logic       en;
    logic       done;
    logic [7:0] d;
    logic [7:0] xd;
    logic       xb;
    logic       xr;
    logic       xo;
  } vec_t;
  vec_t v[13];
  vec_t q[$];
  tx_data_register #(.DATA_WIDTH(8)) dut (
    .i_Pclk(clk),
    .i_Reset(rst_n),
    .i_Enable(en),
    .i_Done(done),
    .i_Data(din),
    .o_Data(dout),
    .o_Busy(busy),
    .o_Ready(ready)
`ifdef TXDATREG_OVERRUN_EN
    ,
    .o_Overrun(ov)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step(input vec_t s);
    vec_t e;
    @(negedge clk);
    en = s.en;
    done = s.done;
    din = s.d;
    q.push_back(s);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: got empty queue expected entry");
    end else begin
      e = q.pop_front();
      chk("data", {24'd0, dout}, {24'd0, e.xd});
      chk("busy", {31'd0, busy}, {31'd0, e.xb});
      chk("ready", {31'd0, ready}, {31'd0, e.xr});
`ifdef TXDATREG_OVERRUN_EN
      chk("overrun", {31'd0, ov}, {31'd0, e.xo});
`endif
    end
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_data"}, {24'd0, dout}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_ready"}, {31'd0, ready}, 32'd0);
`ifdef TXDATREG_OVERRUN_EN
    chk({tag, "_overrun"}, {31'd0, ov}, 32'd0);
`endif
  endtask
  initial begin
    v[0]  = '{1'b1, 1'b0, 8'h53, 8'h53, 1'b1, 1'b1, 1'b0};
    v[1]  = '{1'b0, 1'b0, 8'h00, 8'h53, 1'b1, 1'b0, 1'b0};
    v[2]  = '{1'b1, 1'b0, 8'hE6, 8'h53, 1'b1, 1'b0, 1'b1};
    v[3]  = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
    v[4]  = '{1'b1, 1'b0, 8'h0E, 8'h0E, 1'b1, 1'b1, 1'b1};
    v[5]  = '{1'b0, 1'b0, 8'h00, 8'h0E, 1'b1, 1'b0, 1'b1};
    v[6]  = '{1'b1, 1'b0, 8'hA5, 8'hA5, 1'b1, 1'b1, 1'b0};
    v[7]  = '{1'b1, 1'b1, 8'h11, 8'h00, 1'b0, 1'b0, 1'b1};
    v[8]  = '{1'b1, 1'b1, 8'h11, 8'h11, 1'b1, 1'b1, 1'b1};
    v[9]  = '{1'b1, 1'b0, 8'h22, 8'h11, 1'b1, 1'b0, 1'b1};
    v[10] = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
    v[11] = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
    v[12] = '{1'b1, 1'b0, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1};
    #2 rst_n = 1'b0;
    #1 chk_reset("por");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step(v[i]);
    @(negedge clk);
    en = 1'b0;
    done = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_reset("midrst");
    @(posedge clk);
    #1 chk_reset("rst_edge");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("post_rst_ready", {31'd0, ready}, 32'd0);
    for (int i = 6; i < 13; i++) step(v[i]);
    chk("queue_drained", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
